riscv_l1d_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 data cache that answers the memory stage's L1 request interface (address, read, write, write data in; read data and ready out). It serves read hits combinationally in the same cycle. It refills read misses from the next-level memory through a req/ack handshake, and sends every write through a single-entry write buffer. It sits between the memory stage and the next-level memory port.

---
 rtl/riscv_l1d_responder.sv | 172 +++++++++++++++++
 tb/tb_riscv_l1d_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_l1d_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Read hits answer combinationally; misses refill and writes drain through one next-level port.
module riscv_l1d_responder #(
    parameter int INDEX_BITS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_l1_addr,
    input  logic        i_l1_read,
    input  logic        i_l1_write,
    input  logic [31:0] i_l1_wdata,
    output logic [31:0] o_l1_rdata,
    output logic        o_l1_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [1:0]  o_state,
    output logic        o_wb_full
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    // Handshake: o_mem_req rises registered and stays high with o_mem_we/o_mem_addr/o_mem_wdata
    // stable until the cycle i_mem_ack is sampled high; i_mem_ack is ignored while o_mem_req is low.

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_wb_full;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;
    logic [31:0]           w_addr_aligned;
    logic                  w_hit;
    logic                  w_ack;
    logic                  w_ready;
    logic                  w_issue_wr;
    logic                  w_issue_rd;
    logic                  w_wr_hit;
    logic                  w_fill;
    logic                  w_drain;
    logic                  w_unused;

    assign w_idx          = i_l1_addr[INDEX_BITS+1:2];
    assign w_tag          = i_l1_addr[31:INDEX_BITS+2];
    assign w_fill_idx     = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag     = r_mem_addr[31:INDEX_BITS+2];
    assign w_addr_aligned = {i_l1_addr[31:2], 2'b00};
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_ack          = i_mem_ack && r_mem_req;
    assign w_unused       = ^i_l1_addr[1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        w_wr_hit    = 1'b0;
        w_fill      = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_l1_write) begin
                    w_ready     = 1'b1;
                    w_issue_wr  = 1'b1;
                    w_wr_hit    = w_hit;
                    w_state_nxt = S_WRITE;
                end else if (i_l1_read) begin
                    if (w_hit) begin
                        w_ready = 1'b1;
                    end else begin
                        w_issue_rd  = 1'b1;
                        w_state_nxt = S_REFILL;
                    end
                end
            end
            S_WRITE: begin
                // Buffered write is already in the array, so hits stay coherent while it drains.
                if (i_l1_read && !i_l1_write && w_hit) begin
                    w_ready = 1'b1;
                end
                if (w_ack) begin
                    w_drain     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_REFILL: begin
                if (w_ack) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_full   <= 1'b0;
        end else if (w_issue_wr) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_addr_aligned;
            r_mem_wdata <= i_l1_wdata;
            r_wb_full   <= 1'b1;
        end else if (w_issue_rd) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_addr_aligned;
        end else if (w_drain) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wb_full <= 1'b0;
        end else if (w_fill) begin
            r_mem_req            <= 1'b0;
            r_valid[w_fill_idx]  <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge i_clk) begin
        if (w_wr_hit) begin
            r_data[w_idx] <= i_l1_wdata;
        end else if (w_fill) begin
            r_data[w_fill_idx] <= i_mem_rdata;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

    assign o_l1_rdata  = r_data[w_idx];
    assign o_l1_ready  = w_ready && !i_rst;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_state     = r_state;
    assign o_wb_full   = r_wb_full;

endmodule

// File: tb/tb_riscv_l1d_responder.sv
// Scoreboard bench for riscv_l1d_responder: a transaction-level cache model predicts every cycle,
// a negedge monitor compares the L1 response and the next-level request stream.
module tb_riscv_l1d_responder;

    localparam int IB    = 6;
    localparam int LINES = 1 << IB;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_l1_addr = '0;
    logic        i_l1_read = 1'b0;
    logic        i_l1_write = 1'b0;
    logic [31:0] i_l1_wdata = '0;
    logic [31:0] o_l1_rdata;
    logic        o_l1_ready;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic [1:0]  o_state;
    logic        o_wb_full;

    always #5 i_clk = ~i_clk;

    riscv_l1d_responder #(.INDEX_BITS(IB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_l1_addr(i_l1_addr), .i_l1_read(i_l1_read), .i_l1_write(i_l1_write),
        .i_l1_wdata(i_l1_wdata), .o_l1_rdata(o_l1_rdata), .o_l1_ready(o_l1_ready),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_state(o_state), .o_wb_full(o_wb_full)
    );

    typedef struct packed {
        logic        rst_chk;
        logic        chk_data;
        logic        ready;
        logic        mem_req;
        logic        wb_full;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: each line remembers the full word address it holds; one outstanding memory op at most.
    bit          m_valid [LINES];
    logic [31:0] m_waddr [LINES];
    logic [31:0] m_data  [LINES];
    int          pend_kind = 0;   // 0 none, 1 write-through, 2 refill
    logic [31:0] pend_addr = '0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_waddr[line_of(a)] == (a >> 2));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: apply inputs, predict outputs, advance the model across the edge.
    task automatic step(input bit rst, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit ack, input logic [31:0] ackdata);
        exp_t        e;
        mem_t        m;
        int          li;
        bit          hit;
        logic [31:0] aligned;
        i_rst       = rst;
        i_l1_read   = rd;
        i_l1_write  = wr;
        i_l1_addr   = addr;
        i_l1_wdata  = wdata;
        i_mem_ack   = ack;
        i_mem_rdata = ackdata;
        li      = line_of(addr);
        hit     = model_hit(addr);
        aligned = addr & 32'hFFFF_FFFC;
        e       = '0;
        if (rst) begin
            pend_kind = 0;
            for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
            mem_q.delete();
            e.rst_chk = 1'b1;
        end else begin
            e.mem_req = (pend_kind != 0);
            e.wb_full = (pend_kind == 1);
            if (pend_kind == 0) begin
                if (wr) begin
                    e.ready = 1'b1;
                    if (hit) m_data[li] = wdata;
                    m = '{we: 1'b1, addr: aligned, wdata: wdata};
                    mem_q.push_back(m);
                    pend_kind = 1;
                    pend_addr = aligned;
                end else if (rd) begin
                    if (hit) begin
                        e.ready    = 1'b1;
                        e.chk_data = 1'b1;
                        e.data     = m_data[li];
                    end else begin
                        m = '{we: 1'b0, addr: aligned, wdata: 32'h0};
                        mem_q.push_back(m);
                        pend_kind = 2;
                        pend_addr = aligned;
                    end
                end
            end else begin
                if (pend_kind == 1 && rd && !wr && hit) begin
                    e.ready    = 1'b1;
                    e.chk_data = 1'b1;
                    e.data     = m_data[li];
                end
                if (ack) begin
                    if (pend_kind == 2) begin
                        m_valid[line_of(pend_addr)] = 1'b1;
                        m_waddr[line_of(pend_addr)] = pend_addr >> 2;
                        m_data[line_of(pend_addr)]  = ackdata;
                    end
                    pend_kind = 0;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd_cyc(input logic [31:0] a);
        step(0, 1, 0, a, 32'h0, 0, 32'h0);
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
        step(0, 0, 1, a, d, 0, 32'h0);
    endtask

    task automatic idle_cyc(input bit ack, input logic [31:0] d);
        step(0, 0, 0, 32'h0, 32'h0, ack, d);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] tags [3];
        int          idxs [4];
        tags = '{32'h0, 32'h10, 32'hFF_FFFF};
        idxs = '{0, 1, 2, LINES - 1};
        return (tags[$urandom_range(0, 2)] << (IB + 2)) |
               (32'(idxs[$urandom_range(0, 3)]) << 2) | 32'($urandom_range(0, 3));
    endfunction

    exp_t mon_e;
    mem_t mon_m;

    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("l1_ready", 32'(o_l1_ready), 32'(mon_e.ready));
            if (mon_e.chk_data) check("l1_rdata", o_l1_rdata, mon_e.data);
            check("mem_req", 32'(o_mem_req), 32'(mon_e.mem_req));
            check("wb_full", 32'(o_wb_full), 32'(mon_e.wb_full));
            if (mon_e.rst_chk) begin
                check("rst_mem_we", 32'(o_mem_we), 32'h0);
                check("rst_mem_addr", o_mem_addr, 32'h0);
                check("rst_mem_wdata", o_mem_wdata, 32'h0);
            end
            if (o_mem_req) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_op actual=unexpected_request required=none at %0t", $time);
                end else begin
                    mon_m = mem_q[0];
                    check("mem_we", 32'(o_mem_we), 32'(mon_m.we));
                    check("mem_addr", o_mem_addr, mon_m.addr);
                    if (mon_m.we) check("mem_wdata", o_mem_wdata, mon_m.wdata);
                    if (i_mem_ack) void'(mem_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit          r_rst;
        bit          r_rd;
        bit          r_wr;
        bit          r_ack;
        int          kind;
        @(posedge i_clk);
        #1;
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step(1, 1, 1, 32'h40, 32'h5, 0, 32'h0);

        // Cold read miss, ack two cycles after the request rises, then a hit.
        rd_cyc(32'h40);
        idle_cyc(0, 32'h0);
        idle_cyc(0, 32'h0);
        idle_cyc(1, 32'hDEAD_BEEF);
        rd_cyc(32'h40);

        // Write hit; read served while the write drains.
        wr_cyc(32'h40, 32'h1234_5678);
        rd_cyc(32'h40);
        idle_cyc(1, 32'h0);
        rd_cyc(32'h43);

        // Write miss, no allocate; a read during the drain is dropped, the later one refills.
        wr_cyc(32'h80, 32'hCAFE_0080);
        rd_cyc(32'h80);
        idle_cyc(1, 32'h0);
        rd_cyc(32'h80);
        idle_cyc(1, 32'h0BAD_0080);
        rd_cyc(32'h80);

        // Conflict on one index with two tags; ack in the same cycle the request rises.
        rd_cyc(32'h1040);
        idle_cyc(1, 32'h0000_1040);
        rd_cyc(32'h1040);
        rd_cyc(32'h40);
        idle_cyc(1, 32'h4444_0040);
        rd_cyc(32'h40);

        // Reset mid-refill, then a stray ack with no request outstanding.
        rd_cyc(32'h2040);
        idle_cyc(0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        idle_cyc(1, 32'h7777_7777);
        rd_cyc(32'h40);
        idle_cyc(1, 32'h5555_0040);
        rd_cyc(32'h40);

        // Simultaneous read and write behave as a write.
        step(0, 1, 1, 32'h44, 32'hABCD_0044, 0, 32'h0);
        idle_cyc(0, 32'h0);
        idle_cyc(1, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            kind  = $urandom_range(0, 9);
            r_rd  = (kind <= 4) || (kind == 8);
            r_wr  = (kind >= 5) && (kind <= 8);
            r_ack = (pend_kind != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            step(r_rst, r_rd, r_wr, rand_addr(), $urandom(), r_ack, $urandom());
        end

        idle_cyc(0, 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
